// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller.
// Optional feature macro: MC_CTRL_UPPER_EN (LUI / AUIPC become legal opcodes).
package rv_ctrl_pkg;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Controller states; the encoding is visible on state_o for debug
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC4    = 2'b10,
    M2R_IMM    = 2'b11
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_RS1   = 2'b01,
    SRCA_OLDPC = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JALR   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'b00,
    TRAP_ILLEGAL = 2'b01,
    TRAP_MEMTO   = 2'b10
  } trap_code_e;

  // Opcodes the controller knows how to sequence; anything else traps in DECODE
  function automatic logic isLegalOpcode(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM,
      OPC_BRANCH, OPC_JAL, OPC_JALR: legal = 1'b1;
`ifdef MC_CTRL_UPPER_EN
      OPC_LUI, OPC_AUIPC:            legal = 1'b1;
`endif
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath/memory bundle: status inputs, mux selects, enables, debug.
// master = controller side, slave = datapath side.
interface multi_cycle_controller_if;

  logic [6:0] instr_op_i;
  logic       zero_i;
  logic       mem_ready_i;

  logic       PCWrite_o;
  logic       IRWrite_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       RegWrite_o;
  logic [1:0] MemtoReg_o;
  logic [1:0] ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUop_o;
  logic [1:0] PCSrc_o;
  logic [2:0] state_o;
  logic       retire_o;
  logic [1:0] trap_o;

  modport master (
    input  instr_op_i, zero_i, mem_ready_i,
    output PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, RegWrite_o,
           MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALUop_o, PCSrc_o,
           state_o, retire_o, trap_o
  );

  modport slave (
    output instr_op_i, zero_i, mem_ready_i,
    input  PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, RegWrite_o,
           MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALUop_o, PCSrc_o,
           state_o, retire_o, trap_o
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog counter. r_count holds the number of wait cycles already
// elapsed; expire_o flags the wait cycle that would make it reach MEM_TIMEOUT.
// MEM_TIMEOUT = 0 disables the watchdog entirely. MEM_TIMEOUT must be < 2**TO_W.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam bit              Enabled  = (MEM_TIMEOUT > 0);
  localparam int              LimitInt = Enabled ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [TO_W-1:0] Limit    = LimitInt[TO_W-1:0];

  logic [TO_W-1:0] r_count;

  // Count waiting cycles; cleared whenever the controller is not stalled on memory
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (inc_i && Enabled) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign expire_o = Enabled && inc_i && (r_count == Limit);

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// variable-latency memory handshake, illegal-opcode and memory-timeout traps.
// Optional feature macro: MC_CTRL_UPPER_EN (adds LUI and AUIPC sequencing).
module multi_cycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  multi_cycle_controller_if.master ctrlBus
);

  ctrl_state_e r_state;
  ctrl_state_e w_nextState;
  logic [1:0]  r_trap;
  logic [1:0]  w_trapNext;
  logic        r_retire;
  logic        w_retire;

  logic        w_waiting;
  logic        w_stall;
  logic        w_expire;
  logic        w_isLoad;
  logic        w_isStore;
  logic [6:0]  w_op;
  logic        w_ready;

  logic        w_pcWrite;
  logic        w_irWrite;
  logic        w_iorD;
  logic        w_memRead;
  logic        w_memWrite;
  logic        w_regWrite;
  logic [1:0]  w_memToReg;
  logic [1:0]  w_aluSrcA;
  logic [1:0]  w_aluSrcB;
  logic [1:0]  w_aluOp;
  logic [1:0]  w_pcSrc;

  assign w_op      = ctrlBus.instr_op_i;
  assign w_ready   = ctrlBus.mem_ready_i;
  assign w_isLoad  = (w_op == OPC_LOAD);
  assign w_isStore = (w_op == OPC_STORE);

  // FETCH and MEM are the only states that stall on the memory handshake
  assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_stall   = w_waiting && !w_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (!w_stall),
    .inc_i    (w_stall),
    .expire_o (w_expire)
  );

  // State, sticky trap cause and registered retire pulse
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_FETCH;
      r_trap   <= TRAP_NONE;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_trap   <= w_trapNext;
      r_retire <= w_retire;
    end
  end

  // Next-state: a ready memory response always beats a watchdog expiry
  always_comb begin
    w_nextState = r_state;
    w_trapNext  = r_trap;
    w_retire    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (w_ready) begin
          w_nextState = ST_DECODE;
        end else if (w_expire) begin
          w_nextState = ST_TRAP;
          w_trapNext  = TRAP_MEMTO;
        end
      end
      ST_DECODE: begin
        if (isLegalOpcode(w_op)) begin
          w_nextState = ST_EXEC;
        end else begin
          w_nextState = ST_TRAP;
          w_trapNext  = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (w_op)
          OPC_LOAD, OPC_STORE: w_nextState = ST_MEM;
          OPC_OP, OPC_OP_IMM:  w_nextState = ST_WB;
          OPC_BRANCH, OPC_JAL, OPC_JALR: begin
            w_nextState = ST_FETCH;
            w_retire    = 1'b1;
          end
`ifdef MC_CTRL_UPPER_EN
          OPC_LUI: begin
            w_nextState = ST_FETCH;
            w_retire    = 1'b1;
          end
          OPC_AUIPC: w_nextState = ST_WB;
`endif
          default: begin
            w_nextState = ST_TRAP;
            w_trapNext  = TRAP_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        if (w_ready) begin
          if (w_isLoad) begin
            w_nextState = ST_WB;
          end else begin
            w_nextState = ST_FETCH;
            w_retire    = 1'b1;
          end
        end else if (w_expire) begin
          w_nextState = ST_TRAP;
          w_trapNext  = TRAP_MEMTO;
        end
      end
      ST_WB: begin
        w_nextState = ST_FETCH;
        w_retire    = 1'b1;
      end
      ST_TRAP: w_nextState = ST_TRAP;
      default: w_nextState = ST_FETCH;
    endcase
  end

  // Moore output decode; everything is gated off while reset is held low
  always_comb begin
    w_pcWrite  = 1'b0;
    w_irWrite  = 1'b0;
    w_iorD     = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_regWrite = 1'b0;
    w_memToReg = M2R_ALUOUT;
    w_aluSrcA  = SRCA_PC;
    w_aluSrcB  = SRCB_RS2;
    w_aluOp    = ALU_ADD;
    w_pcSrc    = PCS_ALU;
    if (rst_i) begin
      case (r_state)
        ST_FETCH: begin
          w_memRead = 1'b1;
          w_aluSrcB = SRCB_FOUR;
          if (w_ready) begin
            w_irWrite = 1'b1;
            w_pcWrite = 1'b1;
          end
        end
        ST_DECODE: begin
          w_aluSrcA = SRCA_OLDPC;
          w_aluSrcB = SRCB_IMM;
        end
        ST_EXEC: begin
          case (w_op)
            OPC_LOAD, OPC_STORE: begin
              w_aluSrcA = SRCA_RS1;
              w_aluSrcB = SRCB_IMM;
            end
            OPC_OP: begin
              w_aluSrcA = SRCA_RS1;
              w_aluOp   = ALU_FUNCT;
            end
            OPC_OP_IMM: begin
              w_aluSrcA = SRCA_RS1;
              w_aluSrcB = SRCB_IMM;
              w_aluOp   = ALU_FUNCT;
            end
            OPC_BRANCH: begin
              w_aluSrcA = SRCA_RS1;
              w_aluOp   = ALU_SUB;
              w_pcSrc   = PCS_ALUOUT;
              w_pcWrite = ctrlBus.zero_i;
            end
            OPC_JAL: begin
              w_pcSrc    = PCS_ALUOUT;
              w_pcWrite  = 1'b1;
              w_regWrite = 1'b1;
              w_memToReg = M2R_PC4;
            end
            OPC_JALR: begin
              w_aluSrcA  = SRCA_RS1;
              w_aluSrcB  = SRCB_IMM;
              w_pcSrc    = PCS_JALR;
              w_pcWrite  = 1'b1;
              w_regWrite = 1'b1;
              w_memToReg = M2R_PC4;
            end
`ifdef MC_CTRL_UPPER_EN
            OPC_LUI: begin
              w_regWrite = 1'b1;
              w_memToReg = M2R_IMM;
            end
            OPC_AUIPC: begin
              w_aluSrcA = SRCA_OLDPC;
              w_aluSrcB = SRCB_IMM;
            end
`endif
            default: ;
          endcase
        end
        ST_MEM: begin
          w_iorD     = 1'b1;
          w_memRead  = w_isLoad;
          w_memWrite = w_isStore;
        end
        ST_WB: begin
          w_regWrite = 1'b1;
          w_memToReg = w_isLoad ? M2R_MDR : M2R_ALUOUT;
        end
        default: ;
      endcase
    end
  end

  assign ctrlBus.PCWrite_o  = w_pcWrite;
  assign ctrlBus.IRWrite_o  = w_irWrite;
  assign ctrlBus.IorD_o     = w_iorD;
  assign ctrlBus.MemRead_o  = w_memRead;
  assign ctrlBus.MemWrite_o = w_memWrite;
  assign ctrlBus.RegWrite_o = w_regWrite;
  assign ctrlBus.MemtoReg_o = w_memToReg;
  assign ctrlBus.ALUSrcA_o  = w_aluSrcA;
  assign ctrlBus.ALUSrcB_o  = w_aluSrcB;
  assign ctrlBus.ALUop_o    = w_aluOp;
  assign ctrlBus.PCSrc_o    = w_pcSrc;
  assign ctrlBus.state_o    = r_state;
  assign ctrlBus.retire_o   = r_retire;
  assign ctrlBus.trap_o     = r_trap;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed self-checking bench for multi_cycle_controller.
// Two instances share stimulus: one with the watchdog disabled (MEM_TIMEOUT=0)
// and one with MEM_TIMEOUT=4. Optional feature macro: MC_CTRL_UPPER_EN.
module tb_multi_cycle_controller;
  import rv_ctrl_pkg::*;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  int testCount = 0;
  int failCount = 0;

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  multi_cycle_controller_if busMain ();
  multi_cycle_controller_if busWd ();

  multi_cycle_controller #(.MEM_TIMEOUT(0), .TO_W(8)) dut (
    .clk_i   (clk),
    .rst_i   (rstN),
    .ctrlBus (busMain.master)
  );

  multi_cycle_controller #(.MEM_TIMEOUT(4), .TO_W(8)) dutWd (
    .clk_i   (clk),
    .rst_i   (rstN),
    .ctrlBus (busWd.master)
  );

  // Control outputs packed as {PCW,IRW,IorD,MR,MW,RW,M2R,SrcA,SrcB,ALUop,PCSrc}
  logic [15:0] mainCtrl;
  logic [15:0] wdCtrl;
  assign mainCtrl = {busMain.PCWrite_o, busMain.IRWrite_o, busMain.IorD_o, busMain.MemRead_o,
                     busMain.MemWrite_o, busMain.RegWrite_o, busMain.MemtoReg_o,
                     busMain.ALUSrcA_o, busMain.ALUSrcB_o, busMain.ALUop_o, busMain.PCSrc_o};
  assign wdCtrl   = {busWd.PCWrite_o, busWd.IRWrite_o, busWd.IorD_o, busWd.MemRead_o,
                     busWd.MemWrite_o, busWd.RegWrite_o, busWd.MemtoReg_o,
                     busWd.ALUSrcA_o, busWd.ALUSrcB_o, busWd.ALUop_o, busWd.PCSrc_o};

  function automatic logic [15:0] mkCtrl(input logic pcw, input logic irw, input logic iord,
                                         input logic mr, input logic mw, input logic rw,
                                         input logic [1:0] m2r, input logic [1:0] srcA,
                                         input logic [1:0] srcB, input logic [1:0] aluOp,
                                         input logic [1:0] pcSrc);
    return {pcw, irw, iord, mr, mw, rw, m2r, srcA, srcB, aluOp, pcSrc};
  endfunction

  logic [15:0] cNone, cFetchRdy, cFetchWait, cDecode, cExecLs, cExecOp, cExecOpImm;
  logic [15:0] cBrTaken, cBrNot, cJal, cJalr, cMemRd, cMemWr, cWbAlu, cWbMdr;
  logic [15:0] cLui, cAuipc;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic zero, input logic ready);
    busMain.instr_op_i  = op;
    busMain.zero_i      = zero;
    busMain.mem_ready_i = ready;
    busWd.instr_op_i    = op;
    busWd.zero_i        = zero;
    busWd.mem_ready_i   = ready;
  endtask

  // One clock of the main instance: drive, check mid-cycle, advance to edge+1
  task automatic runCycle(input string tag, input logic [6:0] op, input logic zero,
                          input logic ready, input logic [2:0] expState,
                          input logic [15:0] expCtrl, input logic expRetire,
                          input logic [1:0] expTrap);
    applyStimulus(op, zero, ready);
    @(negedge clk);
    checkOutput({tag, ".state"},  32'(busMain.state_o),  32'(expState));
    checkOutput({tag, ".ctrl"},   32'(mainCtrl),         32'(expCtrl));
    checkOutput({tag, ".retire"}, 32'(busMain.retire_o), 32'(expRetire));
    checkOutput({tag, ".trap"},   32'(busMain.trap_o),   32'(expTrap));
    @(posedge clk);
    #1;
  endtask

  // One clock of the watchdog instance (opcode ADD, zero low)
  task automatic wdCycle(input string tag, input logic ready, input logic [2:0] expState,
                         input logic [15:0] expCtrl, input logic [1:0] expTrap);
    applyStimulus(OPC_OP, 1'b0, ready);
    @(negedge clk);
    checkOutput({tag, ".state"}, 32'(busWd.state_o), 32'(expState));
    checkOutput({tag, ".ctrl"},  32'(wdCtrl),        32'(expCtrl));
    checkOutput({tag, ".trap"},  32'(busWd.trap_o),  32'(expTrap));
    @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge, check the reset state, release just after an edge
  task automatic doReset(input string tag);
    rstN = 1'b0;
    applyStimulus(OPC_OP, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ".state"},   32'(busMain.state_o),  32'(ST_FETCH));
    checkOutput({tag, ".ctrl"},    32'(mainCtrl),         32'(cNone));
    checkOutput({tag, ".retire"},  32'(busMain.retire_o), 32'(1'b0));
    checkOutput({tag, ".trap"},    32'(busMain.trap_o),   32'(TRAP_NONE));
    checkOutput({tag, ".wdState"}, 32'(busWd.state_o),    32'(ST_FETCH));
    checkOutput({tag, ".wdTrap"},  32'(busWd.trap_o),     32'(TRAP_NONE));
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    cNone      = 16'h0000;
    cFetchRdy  = mkCtrl(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    cFetchWait = mkCtrl(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    cDecode    = mkCtrl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);
    cExecLs    = mkCtrl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    cExecOp    = mkCtrl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00);
    cExecOpImm = mkCtrl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00);
    cBrTaken   = mkCtrl(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
    cBrNot     = mkCtrl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
    cJal       = mkCtrl(1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
    cJalr      = mkCtrl(1, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10);
    cMemRd     = mkCtrl(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cMemWr     = mkCtrl(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cWbAlu     = mkCtrl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    cWbMdr     = mkCtrl(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cLui       = mkCtrl(0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    cAuipc     = mkCtrl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00);

    doReset("rst0");

    // ADD with zero-wait memory: FETCH, DECODE, EXEC, WB, retire in the next FETCH
    runCycle("add.f",  OPC_OP, 0, 1, 3'd0, cFetchRdy, 0, 2'b00);
    runCycle("add.d",  OPC_OP, 0, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("add.e",  OPC_OP, 0, 1, 3'd2, cExecOp,   0, 2'b00);
    runCycle("add.wb", OPC_OP, 0, 1, 3'd4, cWbAlu,    0, 2'b00);

    // LW with three memory wait cycles
    runCycle("lw.f",   OPC_LOAD, 0, 1, 3'd0, cFetchRdy, 1, 2'b00);
    runCycle("lw.d",   OPC_LOAD, 0, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("lw.e",   OPC_LOAD, 0, 1, 3'd2, cExecLs,   0, 2'b00);
    runCycle("lw.m0",  OPC_LOAD, 0, 0, 3'd3, cMemRd,    0, 2'b00);
    runCycle("lw.m1",  OPC_LOAD, 0, 0, 3'd3, cMemRd,    0, 2'b00);
    runCycle("lw.m2",  OPC_LOAD, 0, 0, 3'd3, cMemRd,    0, 2'b00);
    runCycle("lw.m3",  OPC_LOAD, 0, 1, 3'd3, cMemRd,    0, 2'b00);
    runCycle("lw.wb",  OPC_LOAD, 0, 1, 3'd4, cWbMdr,    0, 2'b00);

    // BEQ taken and not taken
    runCycle("beq1.f", OPC_BRANCH, 1, 1, 3'd0, cFetchRdy, 1, 2'b00);
    runCycle("beq1.d", OPC_BRANCH, 1, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("beq1.e", OPC_BRANCH, 1, 1, 3'd2, cBrTaken,  0, 2'b00);
    runCycle("beq0.f", OPC_BRANCH, 0, 1, 3'd0, cFetchRdy, 1, 2'b00);
    runCycle("beq0.d", OPC_BRANCH, 0, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("beq0.e", OPC_BRANCH, 0, 1, 3'd2, cBrNot,    0, 2'b00);

    // JAL, JALR, OP_IMM
    runCycle("jal.f",  OPC_JAL,    0, 1, 3'd0, cFetchRdy,  1, 2'b00);
    runCycle("jal.d",  OPC_JAL,    0, 1, 3'd1, cDecode,    0, 2'b00);
    runCycle("jal.e",  OPC_JAL,    0, 1, 3'd2, cJal,       0, 2'b00);
    runCycle("jalr.f", OPC_JALR,   0, 1, 3'd0, cFetchRdy,  1, 2'b00);
    runCycle("jalr.d", OPC_JALR,   0, 1, 3'd1, cDecode,    0, 2'b00);
    runCycle("jalr.e", OPC_JALR,   0, 1, 3'd2, cJalr,      0, 2'b00);
    runCycle("opi.f",  OPC_OP_IMM, 0, 1, 3'd0, cFetchRdy,  1, 2'b00);
    runCycle("opi.d",  OPC_OP_IMM, 0, 1, 3'd1, cDecode,    0, 2'b00);
    runCycle("opi.e",  OPC_OP_IMM, 0, 1, 3'd2, cExecOpImm, 0, 2'b00);
    runCycle("opi.wb", OPC_OP_IMM, 0, 1, 3'd4, cWbAlu,     0, 2'b00);

    // SW with zero-wait memory
    runCycle("sw.f",   OPC_STORE, 0, 1, 3'd0, cFetchRdy, 1, 2'b00);
    runCycle("sw.d",   OPC_STORE, 0, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("sw.e",   OPC_STORE, 0, 1, 3'd2, cExecLs,   0, 2'b00);
    runCycle("sw.m",   OPC_STORE, 0, 1, 3'd3, cMemWr,    0, 2'b00);

    // LUI / AUIPC depend on the upper-immediate build option
    runCycle("lui.f",  OPC_LUI, 0, 1, 3'd0, cFetchRdy, 1, 2'b00);
    runCycle("lui.d",  OPC_LUI, 0, 1, 3'd1, cDecode,   0, 2'b00);
`ifdef MC_CTRL_UPPER_EN
    runCycle("lui.e",    OPC_LUI,   0, 1, 3'd2, cLui,      0, 2'b00);
    runCycle("auipc.f",  OPC_AUIPC, 0, 1, 3'd0, cFetchRdy, 1, 2'b00);
    runCycle("auipc.d",  OPC_AUIPC, 0, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("auipc.e",  OPC_AUIPC, 0, 1, 3'd2, cAuipc,    0, 2'b00);
    runCycle("auipc.wb", OPC_AUIPC, 0, 1, 3'd4, cWbAlu,    0, 2'b00);
    runCycle("auipc.r",  OPC_OP,    0, 0, 3'd0, cFetchWait, 1, 2'b00);
`else
    runCycle("lui.trap", OPC_LUI, 0, 1, 3'd5, cNone, 0, 2'b01);
    runCycle("lui.hold", OPC_LUI, 1, 1, 3'd5, cNone, 0, 2'b01);
`endif

    doReset("rst1");

    // Illegal opcode traps after DECODE and stays dead until reset
    runCycle("ill.f", 7'b1111111, 0, 1, 3'd0, cFetchRdy, 0, 2'b00);
    runCycle("ill.d", 7'b1111111, 0, 1, 3'd1, cDecode,   0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      runCycle("ill.trap", 7'b1111111, 1'(i & 1), 1'((i >> 1) & 1), 3'd5, cNone, 0, 2'b01);
    end

    doReset("rst2");

    // SW with reset pulled mid-MEM: write enable must drop without waiting for an edge
    runCycle("swr.f", OPC_STORE, 0, 1, 3'd0, cFetchRdy, 0, 2'b00);
    runCycle("swr.d", OPC_STORE, 0, 1, 3'd1, cDecode,   0, 2'b00);
    runCycle("swr.e", OPC_STORE, 0, 1, 3'd2, cExecLs,   0, 2'b00);
    applyStimulus(OPC_STORE, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("swr.m.ctrl", 32'(mainCtrl), 32'(cMemWr));
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("swr.async.memWrite", 32'(busMain.MemWrite_o), 32'(1'b0));
    checkOutput("swr.async.ctrl",     32'(mainCtrl),           32'(cNone));
    checkOutput("swr.async.state",    32'(busMain.state_o),    32'(ST_FETCH));
    @(posedge clk);
    #1;
    rstN = 1'b1;
    runCycle("swr.rel", OPC_OP, 0, 1, 3'd0, cFetchRdy, 0, 2'b00);

    doReset("rst3");

    // Watchdog: ready never arrives in FETCH, trap after four wait cycles
    wdCycle("wd.w1", 0, 3'd0, cFetchWait, 2'b00);
    wdCycle("wd.w2", 0, 3'd0, cFetchWait, 2'b00);
    wdCycle("wd.w3", 0, 3'd0, cFetchWait, 2'b00);
    wdCycle("wd.w4", 0, 3'd0, cFetchWait, 2'b00);
    applyStimulus(OPC_OP, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("wd.trap.state",   32'(busWd.state_o),   32'(ST_TRAP));
    checkOutput("wd.trap.code",    32'(busWd.trap_o),    32'(TRAP_MEMTO));
    checkOutput("wd.trap.ctrl",    32'(wdCtrl),          32'(cNone));
    checkOutput("wd.off.state",    32'(busMain.state_o), 32'(ST_FETCH));
    checkOutput("wd.off.trap",     32'(busMain.trap_o),  32'(TRAP_NONE));
    @(posedge clk);
    #1;

    doReset("rst4");

    // Watchdog: ready on the fourth wait cycle wins over expiry
    wdCycle("wdb.w1", 0, 3'd0, cFetchWait, 2'b00);
    wdCycle("wdb.w2", 0, 3'd0, cFetchWait, 2'b00);
    wdCycle("wdb.w3", 0, 3'd0, cFetchWait, 2'b00);
    wdCycle("wdb.w4", 1, 3'd0, cFetchRdy,  2'b00);
    wdCycle("wdb.d",  1, 3'd1, cDecode,    2'b00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Multi-cycle RISC-V main controller: the parametrised successor to the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a variable-latency memory handshake. It traps illegal opcodes and memory timeouts. It drives the datapath muxes and write enables of the multi-cycle CPU from a registered state plus two datapath status inputs.

## Interface
- MEM_TIMEOUT, 0: max cycles waiting on mem_ready_i before trap; 0 disables watchdog.
- TO_W, 8: width of wait counter; MEM_TIMEOUT < 2**TO_W required.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, reset is asynchronous and active-low.
- instr_op_i  in  7  opcode from instruction register; stable after FETCH completes.
- zero_i  in  1  ALU zero flag (BEQ compare).
- mem_ready_i  in  1  memory completes current read/write this cycle.
- PCWrite_o  out  1  PC register load.
- IRWrite_o  out  1  instruction register load.
- IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead_o / MemWrite_o  out  1 each  memory request.
- RegWrite_o  out  1  register-file write.
- MemtoReg_o  out  2  rd data: 00 ALUOut, 01 MDR, 10 OldPC+4, 11 immediate (LUI).
- ALUSrcA_o  out  2  00 PC, 01 rs1, 10 OldPC.
- ALUSrcB_o  out  2  00 rs2, 01 constant 4, 10 immediate.
- ALUop_o  out  2  00 add, 01 subtract (branch), 10 funct-decoded.
- PCSrc_o  out  2  00 ALU result, 01 ALUOut (target), 10 ALU result with bit0 cleared (JALR).
- state_o  out  3  current state encoding, debug.
- retire_o  out  1  one-cycle pulse, instruction completed.
- trap_o  out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs Moore-decoded from state, PCWrite_o/IRWrite_o additionally qualified by mem_ready_i or zero_i as stated. Unlisted outputs 0.
- FETCH: MemRead_o=1, IorD_o=0, ALUSrcA_o=00, ALUSrcB_o=01, ALUop_o=00. When mem_ready_i: IRWrite_o=PCWrite_o=1, PCSrc_o=00 -> DECODE; else stay.
- DECODE: ALUSrcA_o=10, ALUSrcB_o=10 (branch/JAL target into ALUOut). Legal opcode -> EXEC; else -> TRAP, trap_o=01.
- EXEC LOAD/STORE: ALUSrcA_o=01, ALUSrcB_o=10 -> MEM. OP: ALUSrcA_o=01, ALUSrcB_o=00, ALUop_o=10 -> WB. OP_IMM: as OP with ALUSrcB_o=10 -> WB.
- EXEC BRANCH: ALUSrcA_o=01, ALUSrcB_o=00, ALUop_o=01, PCSrc_o=01, PCWrite_o=zero_i; retire -> FETCH.
- EXEC JAL: PCSrc_o=01, PCWrite_o=1, RegWrite_o=1, MemtoReg_o=10; retire -> FETCH. JALR: ALUSrcA_o=01, ALUSrcB_o=10, PCSrc_o=10, otherwise as JAL.
- MEM: IorD_o=1; MemRead_o (load) or MemWrite_o (store) held until mem_ready_i. Load -> WB; store retires -> FETCH.
- WB: RegWrite_o=1, MemtoReg_o=01 for load else 00; retire -> FETCH.
- TRAP: absorbing; all enables 0, only reset exits.
- Watchdog (MEM_TIMEOUT>0): counter clears on entering FETCH/MEM, increments each waiting cycle; when count reaches MEM_TIMEOUT with mem_ready_i low -> TRAP, trap_o=10. mem_ready_i high on the boundary cycle wins.

## Timing
- Reset: state FETCH, counter 0, trap_o 00, retire_o 0; all enables forced 0 while rst_i low.
- Zero-wait memory latencies: branch/JAL/JALR 3 cycles, store 4, OP/OP_IMM 4, load 5; each memory wait cycle adds 1.
- retire_o registered: asserts the cycle after the final state, concurrent with the next FETCH.
- Reset asserted mid-MEM drops MemWrite_o immediately (asynchronous).

## Configuration
- MC_CTRL_UPPER_EN defined: LUI (EXEC: RegWrite_o=1, MemtoReg_o=11 -> FETCH) and AUIPC (EXEC ALUSrcA_o=10, ALUSrcB_o=10 -> WB) legal.
- Undefined: both opcodes trap with trap_o=01.

## Structure
- Package rv_ctrl_pkg: opcode localparams, state enum, ALUop/MemtoReg/PCSrc/trap codes.
- One sub-module mem_wait_timer (counter, clear, expire flag); FSM and output decode in top.

## Test plan
- ADD, mem_ready_i always 1 -> states FETCH, DECODE, EXEC, WB; RegWrite_o in cycle 4; retire_o cycle 5.
- LW with mem_ready_i low 3 cycles in MEM -> MemRead_o, IorD_o=1 held 4 cycles, then WB with MemtoReg_o=01.
- BEQ zero_i=1 vs 0 -> PCWrite_o 1 vs 0 in EXEC, PCSrc_o=01 both.
- Opcode 7'b1111111 -> TRAP after DECODE, trap_o=01, enables stay 0 for 20 cycles until rst_i low.
- MEM_TIMEOUT=4, mem_ready_i never high in FETCH -> TRAP after 4 wait cycles, trap_o=10; variant with ready on 4th cycle -> DECODE.
- SW, rst_i low mid-MEM -> MemWrite_o 0 same cycle; after release state FETCH, trap_o 00.
